// File: rtl/cpu_press_source.sv
// cpu_press_source
// ----------------
// Computer player's side of the 10-bit comparator game. A pacing counter
// produces a one-cycle tick every TICK_DIV enabled cycles. Each tick steps a
// 10-bit Fibonacci XNOR LFSR (taps 10,7), and that LFSR is the value the
// comparator sees on its comp input. On the same tick the comparator's press
// level is sampled. If the FSM is armed, a one-cycle cpu_press pulse follows.
// After the pulse the FSM waits COOLDOWN ticks before it rearms.
//
// Ports
//   clk          in   1   system clock, all logic on posedge
//   reset        in   1   synchronous, active-high reset (highest priority)
//   enable       in   1   1 = play running; 0 = freeze pacing/LFSR, go IDLE
//   press        in   1   comparator press level (evaluated against comp)
//   comp         out 10   LFSR value driven to the comparator (register output)
//   cpu_press    out  1   one-cycle pulse: computer player pressed
//   tick         out  1   one-cycle pacing strobe
//   o_dbg_state  out  2   current FSM state (0 IDLE, 1 ARMED, 2 FIRE, 3 COOLDOWN)
//
// Signalling: there is no valid/ready handshake here. press is a level and is
// only looked at in tick cycles. cpu_press is a fire-and-forget pulse that
// lasts exactly one cycle. The playfield is expected to take it unconditionally.

`timescale 1ns/1ps

module cpu_press_source #(
  parameter int TICK_DIV = 1024,
  parameter int COOLDOWN = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       press,
  output logic [9:0] comp,
  output logic       cpu_press,
  output logic       tick,
  output logic [1:0] o_dbg_state
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
  localparam logic [CD_W-1:0]  CD_LOAD = CD_W'(COOLDOWN);
  localparam logic [CD_W-1:0]  CD_ONE  = CD_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_FIRE     = 2'd2,
    ST_COOLDOWN = 2'd3
  } state_t;

  logic [CNT_W-1:0] r_cnt;
  logic [CD_W-1:0]  r_cd;
  logic [9:0]       r_comp;
  state_t           r_state;
  logic             w_tick;
  logic             w_fb;

  // The tick is combinational so that it lands in the same cycle the
  // counter reaches its last value. Dropping enable suppresses it at once.
  assign w_tick = enable && (r_cnt == CNT_MAX);

  // XNOR feedback keeps all-zero legal. This makes 10'h3FF the lock-up value,
  // and that value is never reached from reset.
  assign w_fb = ~(r_comp[9] ^ r_comp[6]);

  assign tick        = w_tick;
  assign comp        = r_comp;
  assign cpu_press   = (r_state == ST_FIRE);
  assign o_dbg_state = r_state;

  // Pacing counter: it restarts from 0 whenever enable is low. So after
  // re-enable, the first tick is a full TICK_DIV cycles away.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (!enable) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // LFSR: it steps only on ticks and holds its value while frozen.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_comp <= 10'h000;
    end else if (w_tick) begin
      r_comp <= {r_comp[8:0], w_fb};
    end
  end

  // Press FSM. press is sampled in the tick cycle, before the LFSR update
  // lands. That value is the one the comparator evaluated against.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cd    <= '0;
    end else if (!enable) begin
      r_state <= ST_IDLE;
      r_cd    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_ARMED;
        end
        ST_ARMED: begin
          if (w_tick && press) begin
            r_state <= ST_FIRE;
          end
        end
        ST_FIRE: begin
          // A tick in this cycle still steps the LFSR. The press sample is
          // dropped because the FSM is already committed to cooling down.
          r_state <= ST_COOLDOWN;
          r_cd    <= CD_LOAD;
        end
        ST_COOLDOWN: begin
          if (w_tick) begin
            if (r_cd == CD_ONE) begin
              r_state <= ST_ARMED;
              r_cd    <= '0;
            end else begin
              r_cd <= r_cd - CD_ONE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cd    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_press_source.sv
`timescale 1ns/1ps

module tb_cpu_press_source;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       enable;
  logic       press;
  logic [9:0] comp;
  logic       cpu_press;
  logic       tick;
  logic [1:0] dbg_state;

  logic       enable2;
  logic       press2;
  logic [9:0] comp2;
  logic       cpu_press2;
  logic       tick2;
  logic [1:0] dbg_state2;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard queues: expected pulse cycles and expected comp values.
  logic [31:0] exp_q[$];
  logic [9:0]  comp_q[$];

  logic seen [0:1023];

  cpu_press_source #(.TICK_DIV(4), .COOLDOWN(2)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .press       (press),
    .comp        (comp),
    .cpu_press   (cpu_press),
    .tick        (tick),
    .o_dbg_state (dbg_state)
  );

  cpu_press_source #(.TICK_DIV(2), .COOLDOWN(2)) u_dut2 (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable2),
    .press       (press2),
    .comp        (comp2),
    .cpu_press   (cpu_press2),
    .tick        (tick2),
    .o_dbg_state (dbg_state2)
  );

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock and settle 1ns past the edge. Outputs are read there,
  // and new inputs for the next period are applied there.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // After this returns, the bench sits in "period 1": the first period with
  // reset low. Inputs set now are sampled at the edge that ends period 1.
  task automatic do_reset();
    reset   = 1'b1;
    enable  = 1'b0;
    press   = 1'b0;
    enable2 = 1'b0;
    press2  = 1'b0;
    step();
    step();
    check("rst_comp",      32'(comp),      32'h000);
    check("rst_cpu_press", 32'(cpu_press), 32'h0);
    check("rst_tick",      32'(tick),      32'h0);
    check("rst_state",     32'(dbg_state), 32'h0);
    reset = 1'b0;
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int   pulses;
    int   ticks;
    int   dup;
    int   distinct;
    logic t_seen;

    // ---- 1: free run, press low ----
    do_reset();
    enable = 1'b1;
    press  = 1'b0;
    comp_q.push_back(10'h001);
    comp_q.push_back(10'h003);
    comp_q.push_back(10'h007);
    comp_q.push_back(10'h00F);
    check("t1_comp_start", 32'(comp), 32'h000);
    pulses = 0;
    for (int c = 1; c <= 16; c++) begin
      check("t1_tick", 32'(tick), 32'((c % 4) == 0));
      if (cpu_press) pulses++;
      t_seen = tick;
      step();
      if (t_seen) begin
        if (comp_q.size() > 0) check("t1_comp_step", 32'(comp), 32'(comp_q.pop_front()));
        else                   check("t1_extra_tick", 32'(c), 32'h0);
      end
    end
    check("t1_no_pulse", 32'(pulses), 32'h0);
    check("t1_comp_left", 32'(comp_q.size()), 32'h0);

    // ---- 2: press held from reset release ----
    do_reset();
    enable = 1'b1;
    press  = 1'b1;
    exp_q.push_back(32'd5);
    exp_q.push_back(32'd17);
    exp_q.push_back(32'd29);
    for (int c = 1; c <= 40; c++) begin
      if (c == 2) check("t2_armed", 32'(dbg_state), 32'h1);
      if (c == 4) check("t2_first_tick", 32'(tick), 32'h1);
      if (cpu_press) begin
        if (exp_q.size() > 0) check("t2_pulse_cycle", 32'(c), exp_q.pop_front());
        else                  check("t2_extra_pulse", 32'(c), 32'h0);
      end
      step();
    end
    check("t2_pulses_left", 32'(exp_q.size()), 32'h0);

    // ---- 3: enable drop mid-cooldown, then re-enable ----
    do_reset();
    enable = 1'b1;
    press  = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      if (c == 5) check("t3_pulse", 32'(cpu_press), 32'h1);
      step();
    end
    // Period 8: COOLDOWN, counter at its last value, so a tick is due here.
    check("t3_in_cooldown", 32'(dbg_state), 32'h3);
    enable = 1'b0;
    #1;
    check("t3_tick_gated", 32'(tick), 32'h0);
    step();
    check("t3_idle", 32'(dbg_state), 32'h0);
    ticks = 0;
    for (int c = 0; c < 6; c++) begin
      if (tick) ticks++;
      step();
    end
    check("t3_frozen_ticks", 32'(ticks), 32'h0);
    check("t3_frozen_comp", 32'(comp), 32'h001);
    enable = 1'b1;
    press  = 1'b1;
    exp_q.push_back(32'd5);
    for (int r = 1; r <= 8; r++) begin
      if (r == 5) check("t3_resume_comp", 32'(comp), 32'h003);
      if (cpu_press) begin
        if (exp_q.size() > 0) check("t3_reenable_pulse", 32'(r), exp_q.pop_front());
        else                  check("t3_extra_pulse", 32'(r), 32'h0);
      end
      step();
    end
    check("t3_pulses_left", 32'(exp_q.size()), 32'h0);

    // ---- 4: reset during FIRE ----
    do_reset();
    enable = 1'b1;
    press  = 1'b1;
    for (int c = 1; c <= 4; c++) step();
    check("t4_fire", 32'(cpu_press), 32'h1);
    reset = 1'b1;
    step();
    check("t4_cpu_press", 32'(cpu_press), 32'h0);
    check("t4_comp",      32'(comp),      32'h000);
    check("t4_state",     32'(dbg_state), 32'h0);
    reset = 1'b0;

    // ---- 6: press only outside ticks, then once on a tick ----
    do_reset();
    enable = 1'b1;
    exp_q.push_back(32'd33);
    pulses = 0;
    for (int c = 1; c <= 60; c++) begin
      if (cpu_press) begin
        pulses++;
        if (exp_q.size() > 0) check("t6_pulse_cycle", 32'(c), exp_q.pop_front());
        else                  check("t6_extra_pulse", 32'(c), 32'h0);
      end
      if (c == 32)                      press = 1'b1;
      else if ((c % 4) == 0 || c > 28)  press = 1'b0;
      else if (c <= 16)                 press = 1'b1;
      else                              press = 1'($urandom_range(0, 1));
      step();
    end
    check("t6_pulse_count", 32'(pulses), 32'h1);
    check("t6_pulses_left", 32'(exp_q.size()), 32'h0);

    // ---- 5: full LFSR period with TICK_DIV=2 ----
    do_reset();
    enable2 = 1'b1;
    press2  = 1'b0;
    for (int i = 0; i < 1024; i++) seen[i] = 1'b0;
    seen[comp2] = 1'b1;
    ticks  = 0;
    dup    = 0;
    pulses = 0;
    for (int c = 0; c < 2200 && ticks < 1023; c++) begin
      t_seen = tick2;
      if (cpu_press2) pulses++;
      step();
      if (t_seen) begin
        ticks++;
        if (ticks < 1023) begin
          if (seen[comp2]) dup++;
          seen[comp2] = 1'b1;
        end
      end
    end
    distinct = 0;
    for (int i = 0; i < 1024; i++) if (seen[i]) distinct++;
    check("t5_tick_count",  32'(ticks),      32'd1023);
    check("t5_wrap_to_0",   32'(comp2),      32'h000);
    check("t5_duplicates",  32'(dup),        32'h0);
    check("t5_distinct",    32'(distinct),   32'd1023);
    check("t5_no_3ff",      32'(seen[1023]), 32'h0);
    check("t5_no_pulse",    32'(pulses),     32'h0);

    // ---- report ----
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
